// File: rtl/display_command_queue_pkg.sv
// Shared constants and state type for the display command queue.
package display_pkg;

  localparam int DEFAULT_POS_WIDTH  = 12;
  localparam int DEFAULT_CHAR_WIDTH = 7;

  localparam logic [5:0] DISPLAY_OP = 6'b001000;
  localparam logic [5:0] CLEAR_OP   = 6'b001001;
  localparam logic [6:0] BLANK_CHAR = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

endpackage

// File: rtl/display_command_queue_if.sv
// CPU instruction handshake plus text-buffer write port of the display queue.
interface display_command_queue_if #(
  parameter int POS_WIDTH  = display_pkg::DEFAULT_POS_WIDTH,
  parameter int CHAR_WIDTH = display_pkg::DEFAULT_CHAR_WIDTH
);
  logic [31:0]           inst;
  logic [31:0]           rs;
  logic [31:0]           rt;
  logic                  inst_valid;
  logic                  stall;
  logic                  buffer_ready;
  logic                  buffer_write_enable;
  logic [POS_WIDTH-1:0]  position;
  logic [CHAR_WIDTH-1:0] char_code;

  modport master (
    output inst, rs, rt, inst_valid, buffer_ready,
    input  stall, buffer_write_enable, position, char_code
  );

  modport slave (
    input  inst, rs, rt, inst_valid, buffer_ready,
    output stall, buffer_write_enable, position, char_code
  );
endinterface

// File: rtl/display_command_queue_fifo.sv
// Synchronous FIFO holding pending {position, char} writes; pointers carry a wrap bit.
module display_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/display_command_queue.sv
// Decodes DISPLAY/CLEAR, queues character writes and sequences full-screen clears.
module display_command_queue
  import display_pkg::*;
#(
  parameter int POS_WIDTH    = DEFAULT_POS_WIDTH,
  parameter int CHAR_WIDTH   = DEFAULT_CHAR_WIDTH,
  parameter int DEPTH        = 8,
  parameter int SCREEN_CELLS = 2400
) (
  input  logic                    clk,
  input  logic                    reset,
  display_command_queue_if.slave  bus,
  output logic                    busy,
  output logic [7:0]              drop_count
);
  localparam int ENTRY_WIDTH = POS_WIDTH + CHAR_WIDTH;
  localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;
  localparam logic [POS_WIDTH-1:0] LAST_CELL = POS_WIDTH'(SCREEN_CELLS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [POS_WIDTH-1:0]   clear_counter;
  logic [5:0]             op;
  logic [POS_WIDTH-1:0]   pos_field;
  logic [CHAR_WIDTH-1:0]  char_field;
  logic [ENTRY_WIDTH-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_WIDTH-1:0]   fifo_count;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   accept_display;
  logic                   accept_clear;
  logic                   in_range;
  logic                   push;
  logic                   pop;
  logic                   clear_write;
  logic                   unused_bits;

  assign unused_bits = ^{bus.inst[25:0], bus.rs[31:POS_WIDTH], bus.rt[31:CHAR_WIDTH]};
  assign bus.stall   = (state != IDLE) || fifo_full;

  always_comb begin
    op             = bus.inst[31:26];
    pos_field      = bus.rs[POS_WIDTH-1:0];
    char_field     = bus.rt[CHAR_WIDTH-1:0];
    accept_display = bus.inst_valid && !bus.stall && (op == DISPLAY_OP);
    accept_clear   = bus.inst_valid && !bus.stall && (op == CLEAR_OP);
    in_range       = (pos_field <= LAST_CELL);
    push           = accept_display && in_range;
    pop            = !fifo_empty && bus.buffer_ready && (state == IDLE || state == DRAIN);
    clear_write    = (state == CLEAR) && bus.buffer_ready;
    count_next     = fifo_count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  // DRAIN waits on pre-edge emptiness, so the clear starts one edge after the last pop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_clear) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = CLEAR;
      CLEAR:   if (clear_write && clear_counter == LAST_CELL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  display_cmd_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({pos_field, char_field}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      clear_counter           <= '0;
      bus.buffer_write_enable <= 1'b0;
      bus.position            <= '0;
      bus.char_code           <= '0;
      busy                    <= 1'b0;
      drop_count              <= '0;
    end else begin
      state <= state_next;
      busy  <= (count_next != '0) || (state_next != IDLE);

      if (pop) begin
        bus.buffer_write_enable <= 1'b1;
        bus.position            <= fifo_head[ENTRY_WIDTH-1:CHAR_WIDTH];
        bus.char_code           <= fifo_head[CHAR_WIDTH-1:0];
      end else if (clear_write) begin
        bus.buffer_write_enable <= 1'b1;
        bus.position            <= clear_counter;
        bus.char_code           <= CHAR_WIDTH'(BLANK_CHAR);
      end else begin
        bus.buffer_write_enable <= 1'b0;
        bus.position            <= '0;
        bus.char_code           <= '0;
      end

      if (state == DRAIN && fifo_empty)
        clear_counter <= '0;
      else if (clear_write)
        clear_counter <= (clear_counter == LAST_CELL) ? '0 : clear_counter + 1'b1;

      if (accept_display && !in_range && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_display_command_queue.sv
// Randomised and directed bench for display_command_queue with a queue-based reference model.
module tb_display_command_queue;
  localparam int DEPTH = 8;
  localparam int CELLS = 2400;
  localparam logic [5:0] OP_DISP = 6'b001000;
  localparam logic [5:0] OP_CLR  = 6'b001001;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_CLEARING = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  display_command_queue_if #(.POS_WIDTH(12), .CHAR_WIDTH(7)) bus ();

  display_command_queue #(
    .POS_WIDTH    (12),
    .CHAR_WIDTH   (7),
    .DEPTH        (DEPTH),
    .SCREEN_CELLS (CELLS)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 0;
  int ready_mode = 0;

  // Reference model: pending writes as a queue of (pos<<8 | char), plus clear progress.
  int mq[$];
  int m_mode = M_IDLE;
  int m_ctr = 0;
  int m_we = 0, m_pos = 0, m_char = 0, m_busy = 0, m_drop = 0;

  int log_pos[$];
  int log_char[$];
  int log_cyc[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_stall();
    return (m_mode != M_IDLE || mq.size() == DEPTH) ? 1 : 0;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    int sz, pos, e;
    bit acc_d, acc_c, st;
    if (rst) begin
      mq.delete();
      m_mode = M_IDLE; m_ctr = 0;
      m_we = 0; m_pos = 0; m_char = 0; m_busy = 0; m_drop = 0;
    end else begin
      sz    = mq.size();
      pos   = int'(bus.rs[11:0]);
      st    = (model_stall() != 0);
      acc_d = bus.inst_valid && !st && bus.inst[31:26] == OP_DISP;
      acc_c = bus.inst_valid && !st && bus.inst[31:26] == OP_CLR;
      m_we = 0; m_pos = 0; m_char = 0;
      if (m_mode != M_CLEARING && sz > 0 && bus.buffer_ready) begin
        e = mq.pop_front();
        m_we = 1; m_pos = e >> 8; m_char = e & 8'hFF;
      end else if (m_mode == M_CLEARING && bus.buffer_ready) begin
        m_we = 1; m_pos = m_ctr; m_char = 32'h20;
        if (m_ctr == CELLS - 1) m_mode = M_IDLE;
        else m_ctr++;
      end else if (m_mode == M_DRAIN && sz == 0) begin
        m_mode = M_CLEARING; m_ctr = 0;
      end
      if (acc_c) m_mode = M_DRAIN;
      if (acc_d) begin
        if (pos < CELLS) mq.push_back((pos << 8) | int'(bus.rt[6:0]));
        else if (m_drop < 255) m_drop++;
      end
      m_busy = (mq.size() > 0 || m_mode != M_IDLE) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("write_enable", int'(bus.buffer_write_enable), m_we);
      check("position", int'(bus.position), m_pos);
      check("char_code", int'(bus.char_code), m_char);
      check("busy", int'(busy), m_busy);
      check("drop_count", int'(drop_count), m_drop);
      check("stall", int'(bus.stall), model_stall());
    end
    if (bus.buffer_write_enable) begin
      log_pos.push_back(int'(bus.position));
      log_char.push_back(int'(bus.char_code));
      log_cyc.push_back(cyc);
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (ready_mode == 1) bus.buffer_ready = !bus.buffer_ready;
    else if (ready_mode == 2) bus.buffer_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_rs(input int pos);
    return {20'($urandom), 12'(pos)};
  endfunction

  function automatic logic [31:0] mk_rt(input int ch);
    return {25'($urandom), 7'(ch)};
  endfunction

  task automatic clear_log();
    log_pos.delete(); log_char.delete(); log_cyc.delete();
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] rs_v, input logic [31:0] rt_v,
                       output int acc_edge);
    int waited = 0;
    bit done = 0;
    acc_edge = -1;
    bus.inst = {op, 26'($urandom)};
    bus.rs = rs_v;
    bus.rt = rt_v;
    bus.inst_valid = 1'b1;
    while (!done) begin
      #1;
      if (!bus.stall) begin
        done = 1;
        acc_edge = cyc + 1;
      end
      @(negedge clk);
      #1;
      if (!done && ++waited > 20000) begin
        check("issue_timeout", 1, 0);
        done = 1;
      end
    end
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || bus.stall) && n < limit) begin
      tick(1);
      n++;
    end
    check("idle_within_bound", int'(busy || bus.stall), 0);
  endtask

  task automatic check_clear_seq(input int first, input string name);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (first + i >= log_pos.size()) bad++;
      else if (log_pos[first + i] != i || log_char[first + i] != 32'h20) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int acc, n, r, clears;
    logic [5:0] rop;
    bus.inst = '0; bus.rs = '0; bus.rt = '0;
    bus.inst_valid = 1'b0; bus.buffer_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    cmp_en = 1;
    rst = 1'b0;
    tick(1);
    check("reset_busy", int'(busy), 0);
    check("reset_stall", int'(bus.stall), 0);
    check("reset_drop", int'(drop_count), 0);

    // Single write latency
    clear_log();
    issue(OP_DISP, mk_rs(5), mk_rt(8'h41), acc);
    wait_idle(20);
    check("t1_count", log_pos.size(), 1);
    check("t1_pos", log_pos[0], 5);
    check("t1_char", log_char[0], 32'h41);
    check("t1_latency", log_cyc[0], acc + 1);

    // Fill FIFO with ready low, ninth is held
    bus.buffer_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 8; i++) issue(OP_DISP, mk_rs(i), mk_rt(8'h30 + i), acc);
    check("t2_stall_full", int'(bus.stall), 1);
    fork
      issue(OP_DISP, mk_rs(8), mk_rt(8'h38), acc);
      begin
        tick(4);
        check("t2_stall_held", int'(bus.stall), 1);
        bus.buffer_ready = 1'b1;
      end
    join
    wait_idle(50);
    check("t2_count", log_pos.size(), 9);
    for (int i = 0; i < 9 && i < log_pos.size(); i++) begin
      check("t2_pos", log_pos[i], i);
      check("t2_char", log_char[i], 32'h30 + i);
    end

    // Out-of-range drops and saturation
    clear_log();
    issue(OP_DISP, mk_rs(2400), mk_rt(1), acc);
    issue(OP_DISP, mk_rs(4095), mk_rt(2), acc);
    tick(3);
    check("t3_no_write", log_pos.size(), 0);
    check("t3_drop2", int'(drop_count), 2);
    for (int i = 0; i < 300; i++)
      issue(OP_DISP, mk_rs($urandom_range(2400, 4095)), mk_rt(3), acc);
    tick(2);
    check("t3_drop_sat", int'(drop_count), 255);

    // Queued writes drain before the clear
    bus.buffer_ready = 1'b0;
    clear_log();
    issue(OP_DISP, mk_rs(100), mk_rt(8'h11), acc);
    issue(OP_DISP, mk_rs(2399), mk_rt(8'h7f), acc);
    issue(OP_CLR, mk_rs(0), mk_rt(0), acc);
    check("t4_stall_after_clear", int'(bus.stall), 1);
    tick(3);
    bus.buffer_ready = 1'b1;
    wait_idle(6000);
    check("t4_count", log_pos.size(), CELLS + 2);
    check("t4_first_pos", log_pos[0], 100);
    check("t4_first_char", log_char[0], 32'h11);
    check("t4_second_pos", log_pos[1], 2399);
    check("t4_second_char", log_char[1], 32'h7f);
    check_clear_seq(2, "t4_clear_seq_errors");

    // Clear with ready toggling every cycle
    clear_log();
    ready_mode = 1;
    issue(OP_CLR, mk_rs(0), mk_rt(0), acc);
    wait_idle(8000);
    ready_mode = 0;
    bus.buffer_ready = 1'b1;
    check("t5_count", log_pos.size(), CELLS);
    check_clear_seq(0, "t5_clear_seq_errors");

    // Asynchronous reset in the middle of a clear
    clear_log();
    issue(OP_CLR, mk_rs(0), mk_rt(0), acc);
    n = 0;
    while (log_pos.size() < 1001 && n < 3000) begin
      tick(1);
      n++;
    end
    check("t6_reached_1000", int'(log_pos.size() >= 1001), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_we", int'(bus.buffer_write_enable), 0);
    check("t6_rst_pos", int'(bus.position), 0);
    check("t6_rst_char", int'(bus.char_code), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_stall", int'(bus.stall), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t6_post_stall", int'(bus.stall), 0);
    check("t6_post_busy", int'(busy), 0);
    clear_log();
    issue(OP_DISP, mk_rs(77), mk_rt(8'h55), acc);
    wait_idle(20);
    check("t6_new_count", log_pos.size(), 1);
    check("t6_new_pos", log_pos[0], 77);
    check("t6_new_char", log_char[0], 32'h55);

    // Random traffic against the model
    ready_mode = 2;
    clears = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3 && clears < 2) begin
        clears++;
        issue(OP_CLR, mk_rs($urandom_range(0, 4095)), mk_rt($urandom_range(0, 127)), acc);
      end else if (r < 80) begin
        issue(OP_DISP, mk_rs($urandom_range(0, CELLS - 1)), mk_rt($urandom_range(0, 127)), acc);
      end else if (r < 88) begin
        issue(OP_DISP, mk_rs($urandom_range(CELLS, 4095)), mk_rt($urandom_range(0, 127)), acc);
      end else begin
        rop = 6'($urandom);
        if (rop == OP_DISP || rop == OP_CLR) rop = rop ^ 6'b100000;
        issue(rop, mk_rs($urandom_range(0, 4095)), mk_rt($urandom_range(0, 127)), acc);
      end
      tick($urandom_range(0, 3));
    end
    wait_idle(20000);
    ready_mode = 0;
    bus.buffer_ready = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_command_queue.md
Name: display_command_queue

Overview:
Parametrised successor to the single-cycle display dispatcher. Decodes DISPLAY and CLEAR instructions from the execute stage and buffers character writes in a DEPTH-entry FIFO. Drains the FIFO into the text buffer write port under a ready handshake, and stalls the CPU when it cannot accept. CLEAR is a hardware sequencer that blanks every screen cell, so software does not have to loop.

Parameters:
POS_WIDTH, 12, width of position field (rs[POS_WIDTH-1:0])
CHAR_WIDTH, 7, width of char_code field (rt[CHAR_WIDTH-1:0])
DEPTH, 8, FIFO entries; power of two, >= 2
SCREEN_CELLS, 2400, number of valid positions (80x30); must be <= 2**POS_WIDTH
DISPLAY_OP, 6'b001000, opcode for single-character write
CLEAR_OP, 6'b001001, opcode for full-screen clear
BLANK_CHAR, 7'h20, character written by CLEAR

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
inst  in  32  instruction; opcode = inst[31:26]
rs  in  32  position operand
rt  in  32  character operand
inst_valid  in  1  inst/rs/rt are valid this cycle
stall  out  1  combinational; CPU must hold the instruction while high
buffer_ready  in  1  text buffer can take a write this cycle
buffer_write_enable  out  1  registered write strobe
position  out  POS_WIDTH  registered write address
char_code  out  CHAR_WIDTH  registered write data
busy  out  1  registered; high while FIFO is non-empty or state != IDLE
drop_count  out  8  registered saturating count of discarded out-of-range writes

Behaviour:
- Reset (async, active-high): FIFO empty; state IDLE; clear counter 0; buffer_write_enable=0; position=0; char_code=0; busy=0; drop_count=0. Assertion mid-CLEAR or mid-drain aborts and discards all pending entries.
- stall = (state != IDLE) || fifo_full. The stall is asserted for any instruction, which keeps the interface simple.
- Accept means inst_valid && !stall && (op==DISPLAY_OP || op==CLEAR_OP). Other opcodes are ignored.
- DISPLAY accept:
  - If rs[POS_WIDTH-1:0] < SCREEN_CELLS, push {position, char} at the edge.
  - Otherwise do not push, and drop_count increments, saturating at 255.
- CLEAR accept: state becomes DRAIN at the edge. Nothing is pushed.
- Pop/output, IDLE or DRAIN: on an edge where the FIFO is non-empty (occupancy before the edge) and buffer_ready=1, pop the head and register it onto position/char_code with buffer_write_enable=1. On every other edge, buffer_write_enable=0 and position=0, char_code=0.
- No bypass: a push at edge N becomes visible to the pop at edge N+1 at the earliest. Minimum latency is accept edge N to buffer_write_enable high in cycle after edge N+1.
- Simultaneous push and pop in the same cycle is legal. Occupancy is unchanged, and fifo_full is evaluated on the pre-edge occupancy.
- State machine:
  - IDLE: CLEAR accept goes to DRAIN.
  - DRAIN: stays until the FIFO is empty and the last pop has been issued. Once fifo_empty, goes to CLEAR with counter=0.
  - CLEAR: on each edge with buffer_ready=1, emit position=counter, char_code=BLANK_CHAR, write_enable=1, then counter++. After emitting SCREEN_CELLS-1, go to IDLE.
  - With buffer_ready=0: hold state and counter, and write_enable=0.
- Counter width is POS_WIDTH. With the legal parameters it never wraps.
- busy deasserts on the edge the final write (FIFO or clear) is registered.

Decomposition:
- Shared package display_pkg holds:
  - opcode constants DISPLAY_OP and CLEAR_OP
  - BLANK_CHAR
  - the state enum {IDLE, DRAIN, CLEAR}
  - the default widths POS_WIDTH and CHAR_WIDTH
- One sub-module, display_cmd_fifo: synchronous FIFO parametrised by width (POS_WIDTH+CHAR_WIDTH) and DEPTH, with push, pop, full, empty and head outputs. Pointers are one extra bit wide for the full/empty distinction.
- The top level contains the decode, the clear sequencer and the output registers.

Test Plan:
- Reset, then DISPLAY rs=5, rt=0x41 with buffer_ready=1 -> exactly one cycle of write_enable=1, position=5, char_code=0x41, starting in the cycle after the second edge following accept; busy falls on that edge.
- buffer_ready=0, then issue 9 DISPLAYs at positions 0..8 (DEPTH=8) -> stall rises after the 8th accept and the 9th is held. Raise buffer_ready -> writes 0..8 appear in order with no loss and no duplicates.
- DISPLAY rs=2400 then rs=4095 -> no write_enable, drop_count=2. Issue 300 out-of-range writes -> drop_count saturates at 255.
- Two DISPLAYs queued, then CLEAR -> both queued writes are emitted first. Then 2400 writes at positions 0..2399 with char_code=0x20. stall stays high from CLEAR accept until the edge after position 2399, then returns to IDLE.
- During CLEAR, toggle buffer_ready 1/0 every cycle -> no position is skipped or repeated, and total writes = 2400.
- Assert reset at clear position 1000 -> all outputs go to 0 immediately (async). After release, state is IDLE, stall=0, FIFO empty, and a new DISPLAY works normally.
